// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the mips_fetch instruction-fetch stage.
package mips_fetch_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int unsigned FUNCT_W    = FUNCT_MSB - FUNCT_LSB + 1;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [PC_W-1:0] PC_INC           = 32'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// Instruction-memory, decoder handshake and status signals of mips_fetch.
interface mips_fetch_if;
  import mips_fetch_pkg::*;

  logic                imem_req;
  logic [PC_W-1:0]     imem_addr;
  logic [INST_W-1:0]   imem_rdata;
  logic                dec_valid;
  logic                dec_ready;
  logic [INST_W-1:0]   inst;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  funct;
  logic [PC_W-1:0]     inst_pc;
  logic                except;
  logic                redirect_valid;
  logic [PC_W-1:0]     redirect_pc;
  logic                halted;
  logic [PC_W-1:0]     fault_pc;

  modport master (
    output imem_req, imem_addr, dec_valid, inst, opcode, funct, inst_pc, halted, fault_pc,
    input  imem_rdata, dec_ready, except, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, inst, opcode, funct, inst_pc, halted, fault_pc,
    output imem_rdata, dec_ready, except, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/mips_fetch_fifo.sv
// Circular instruction buffer holding {inst, pc} pairs; flush empties it in one cycle.
module mips_fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     wdata_i,
  output fetch_entry_t     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_c, do_pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // A push into a full buffer is legal only when the head leaves the same cycle.
  always_comb begin
    do_pop_c  = pop_i & ~empty_o;
    do_push_c = push_i & (~full_o | do_pop_c);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push_c && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mips_fetch.sv
// MIPS instruction-fetch stage: PC sequencing, imem issue, buffering and decoder handshake.
// Optional MIPS_FETCH_STATS_EN adds the fetch_count output of accepted instructions.
module mips_fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic           clock,
  input  logic           reset,
  mips_fetch_if.master   fif
`ifdef MIPS_FETCH_STATS_EN
  ,
  output logic [31:0]    fetch_count
`endif
);

  localparam int unsigned     CNT_W       = $clog2(DEPTH + 1);
  localparam int unsigned     OCC_W       = CNT_W + 1;
  localparam logic [PC_W-1:0] RESET_PC_AL = {RESET_PC[PC_W-1:2], 2'b00};

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic            inflight_q, inflight_d;
  logic            inflight_epoch_q, inflight_epoch_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PC_W-1:0] fault_pc_q, fault_pc_d;

  fetch_entry_t     head_c;
  fetch_entry_t     push_data_c;
  logic             fifo_full_c, fifo_empty_c;
  logic [CNT_W-1:0] fifo_count_c;
  logic [OCC_W-1:0] occ_c;
  logic             dec_valid_c, accept_c, take_except_c, space_ok_c;
  logic             issue_c, push_c, flush_c;

  mips_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push_c),
    .pop_i   (accept_c),
    .flush_i (flush_c),
    .wdata_i (push_data_c),
    .rdata_o (head_c),
    .full_o  (fifo_full_c),
    .empty_o (fifo_empty_c),
    .count_o (fifo_count_c)
  );

  // A slot vacated by this cycle's pop counts as free, so a single request
  // in flight plus one buffered word sustains one instruction per cycle.
  always_comb begin
    dec_valid_c   = (state_q == RUN) & ~fifo_empty_c;
    accept_c      = dec_valid_c & fif.dec_ready;
    take_except_c = accept_c & fif.except;
    occ_c         = OCC_W'(fifo_count_c) + OCC_W'(inflight_q) - OCC_W'(accept_c);
    space_ok_c    = inflight_q ? (occ_c < OCC_W'(DEPTH)) : (~fifo_full_c | accept_c);
    push_data_c   = '{inst: fif.imem_rdata, pc: inflight_pc_q};
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    epoch_d          = epoch_q;
    inflight_d       = 1'b0;
    inflight_epoch_d = inflight_epoch_q;
    inflight_pc_d    = inflight_pc_q;
    fault_pc_d       = fault_pc_q;
    issue_c          = 1'b0;
    push_c           = 1'b0;
    flush_c          = 1'b0;
    case (state_q)
      RUN: begin
        push_c = inflight_q & (inflight_epoch_q == epoch_q);
        if (take_except_c) begin
          state_d    = HALT;
          fault_pc_d = head_c.pc;
          flush_c    = 1'b1;
          epoch_d    = ~epoch_q;
        end else if (fif.redirect_valid) begin
          pc_d    = align_word(fif.redirect_pc);
          flush_c = 1'b1;
          epoch_d = ~epoch_q;
        end else if (space_ok_c && reset) begin
          issue_c          = 1'b1;
          pc_d             = pc_q + PC_INC;
          inflight_d       = 1'b1;
          inflight_epoch_d = epoch_q;
          inflight_pc_d    = pc_q;
        end
      end
      HALT: begin
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q          <= RUN;
      pc_q             <= RESET_PC_AL;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      inflight_pc_q    <= '0;
      fault_pc_q       <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      inflight_pc_q    <= inflight_pc_d;
      fault_pc_q       <= fault_pc_d;
    end
  end

`ifdef MIPS_FETCH_STATS_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clock) begin
    if (!reset)                          fetch_count_q <= '0;
    else if (accept_c && !fif.except)    fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign fetch_count = fetch_count_q;
`endif

  // Head fields are forced to zero whenever nothing is presented.
  assign fif.imem_req  = issue_c;
  assign fif.imem_addr = pc_q;
  assign fif.dec_valid = dec_valid_c;
  assign fif.inst      = dec_valid_c ? head_c.inst : '0;
  assign fif.inst_pc   = dec_valid_c ? head_c.pc   : '0;
  assign fif.opcode    = fif.inst[OPCODE_MSB:OPCODE_LSB];
  assign fif.funct     = fif.inst[FUNCT_MSB:FUNCT_LSB];
  assign fif.halted    = (state_q == HALT);
  assign fif.fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch: streaming, stall, redirect, wrap, reset and exception halt.
module tb_mips_fetch;

  logic        clock;
  logic        reset;
  logic [31:0] rdata_q;
  int          tests_run;
  int          tests_failed;

  mips_fetch_if fif();

`ifdef MIPS_FETCH_STATS_EN
  logic [31:0] fetch_count;
`endif

  mips_fetch #(.RESET_PC(32'h0040_0000), .DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .fif   (fif)
`ifdef MIPS_FETCH_STATS_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: word returned one cycle after the request is addr ^ A5A5A5A5.
  always @(posedge clock) rdata_q <= fif.imem_req ? (fif.imem_addr ^ 32'hA5A5_A5A5) : 32'h0;
  assign fif.imem_rdata = rdata_q;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hA5A5_A5A5;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    fif.dec_ready = 1'b1; fif.except = 1'b0;
    fif.redirect_valid = 1'b0; fif.redirect_pc = 32'h0;
    reset = 1'b0;
    repeat (3) tick();
    #1;
    tests_run++; if (fif.imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", fif.imem_req); end
    tests_run++; if (fif.dec_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", fif.dec_valid); end
    tests_run++; if (fif.halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted: got %b want 0", fif.halted); end
    tests_run++; if (fif.fault_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_fault_pc: got %h want 0", fif.fault_pc); end
    tests_run++; if (fif.inst !== 32'h0 || fif.inst_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_head: got inst %h pc %h want 0/0", fif.inst, fif.inst_pc); end
`ifdef MIPS_FETCH_STATS_EN
    tests_run++; if (fetch_count !== 32'h0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
`endif
    reset = 1'b1;
    #1;
    tests_run++; if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h0040_0000) begin tests_failed++; $display("FAIL first_issue: got req %b addr %h want 1 00400000", fif.imem_req, fif.imem_addr); end
    tick();
    tests_run++; if (fif.imem_addr !== 32'h0040_0004 || fif.dec_valid !== 1'b0) begin tests_failed++; $display("FAIL second_issue: got addr %h valid %b want 00400004 0", fif.imem_addr, fif.dec_valid); end
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] pc, w, inst_w;
    logic [5:0]  op, fn;
    for (int k = 2; k <= 7; k++) begin
      #1;
      pc = 32'h0040_0000 + 32'(4 * (k - 2));
      w  = 32'h0040_0000 + 32'(4 * k);
      inst_w = mem_word(pc);
      tests_run++; if (fif.dec_valid !== 1'b1 || fif.inst_pc !== pc) begin tests_failed++; $display("FAIL stream_pc c%0d: got valid %b pc %h want 1 %h", k, fif.dec_valid, fif.inst_pc, pc); end
      tests_run++; if (fif.inst !== inst_w) begin tests_failed++; $display("FAIL stream_inst c%0d: got %h want %h", k, fif.inst, inst_w); end
      tests_run++; if (fif.imem_req !== 1'b1 || fif.imem_addr !== w) begin tests_failed++; $display("FAIL stream_addr c%0d: got req %b addr %h want 1 %h", k, fif.imem_req, fif.imem_addr, w); end
      if (k == 2) begin
        op = inst_w[31:26]; fn = inst_w[5:0];
        tests_run++; if (fif.opcode !== op || fif.funct !== fn) begin tests_failed++; $display("FAIL stream_fields: got op %h fn %h want %h %h", fif.opcode, fif.funct, op, fn); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc;
    fif.dec_ready = 1'b0;
    fif.except = 1'b1;
    for (int k = 8; k <= 12; k++) begin
      #1;
      tests_run++; if (fif.dec_valid !== 1'b1 || fif.inst_pc !== 32'h0040_0018 || fif.inst !== mem_word(32'h0040_0018)) begin tests_failed++; $display("FAIL stall_hold c%0d: got valid %b pc %h inst %h", k, fif.dec_valid, fif.inst_pc, fif.inst); end
      tests_run++; if (fif.imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_req c%0d: got %b want 0", k, fif.imem_req); end
      tests_run++; if (fif.halted !== 1'b0) begin tests_failed++; $display("FAIL stall_except c%0d: got halted %b want 0", k, fif.halted); end
`ifdef MIPS_FETCH_STATS_EN
      tests_run++; if (fetch_count !== 32'd6) begin tests_failed++; $display("FAIL stall_count c%0d: got %0d want 6", k, fetch_count); end
`endif
      tick();
    end
    fif.except = 1'b0;
    fif.dec_ready = 1'b1;
    for (int k = 13; k <= 16; k++) begin
      #1;
      pc = 32'h0040_0018 + 32'(4 * (k - 13));
      tests_run++; if (fif.dec_valid !== 1'b1 || fif.inst_pc !== pc || fif.inst !== mem_word(pc)) begin tests_failed++; $display("FAIL drain c%0d: got valid %b pc %h inst %h want pc %h", k, fif.dec_valid, fif.inst_pc, fif.inst, pc); end
      if (k == 16) begin
        tests_run++; if (fif.imem_addr !== 32'h0040_002C) begin tests_failed++; $display("FAIL drain_addr: got %h want 0040002c", fif.imem_addr); end
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    fif.redirect_valid = 1'b1;
    fif.redirect_pc = 32'h0040_0100;
    #1;
    tests_run++; if (fif.imem_req !== 1'b0 || fif.inst_pc !== 32'h0040_0028) begin tests_failed++; $display("FAIL redir_cycle: got req %b pc %h want 0 00400028", fif.imem_req, fif.inst_pc); end
    tick();
    fif.redirect_valid = 1'b0;
    #1;
    tests_run++; if (fif.dec_valid !== 1'b0 || fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h0040_0100) begin tests_failed++; $display("FAIL redir_resume: got valid %b req %b addr %h want 0 1 00400100", fif.dec_valid, fif.imem_req, fif.imem_addr); end
`ifdef MIPS_FETCH_STATS_EN
    tests_run++; if (fetch_count !== 32'd11) begin tests_failed++; $display("FAIL redir_count: got %0d want 11", fetch_count); end
`endif
    tick(); #1;
    tests_run++; if (fif.dec_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_stale: got valid %b pc %h want 0", fif.dec_valid, fif.inst_pc); end
    tick(); #1;
    tests_run++; if (fif.dec_valid !== 1'b1 || fif.inst_pc !== 32'h0040_0100 || fif.inst !== mem_word(32'h0040_0100)) begin tests_failed++; $display("FAIL redir_target: got valid %b pc %h inst %h want pc 00400100", fif.dec_valid, fif.inst_pc, fif.inst); end
    tick(); #1;
    tests_run++; if (fif.inst_pc !== 32'h0040_0104) begin tests_failed++; $display("FAIL redir_next: got %h want 00400104", fif.inst_pc); end
    tick();
  endtask

  task automatic test_wrap();
    fif.redirect_valid = 1'b1;
    fif.redirect_pc = 32'hFFFF_FFFB;
    #1;
    tests_run++; if (fif.imem_req !== 1'b0) begin tests_failed++; $display("FAIL wrap_redir_req: got %b want 0", fif.imem_req); end
    tick();
    fif.redirect_valid = 1'b0;
    #1;
    tests_run++; if (fif.imem_addr !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL wrap_addr0: got %h want fffffff8", fif.imem_addr); end
    tick(); #1;
    tests_run++; if (fif.imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_addr1: got %h want fffffffc", fif.imem_addr); end
    tick(); #1;
    tests_run++; if (fif.imem_addr !== 32'h0000_0000 || fif.inst_pc !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL wrap_addr2: got addr %h pc %h want 00000000 fffffff8", fif.imem_addr, fif.inst_pc); end
    tick(); #1;
    tests_run++; if (fif.inst_pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pc1: got %h want fffffffc", fif.inst_pc); end
    tick(); #1;
    tests_run++; if (fif.inst_pc !== 32'h0000_0000 || fif.inst !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL wrap_pc2: got pc %h inst %h want 00000000 a5a5a5a5", fif.inst_pc, fif.inst); end
    tick();
  endtask

  task automatic test_reset_mid();
    fif.dec_ready = 1'b0;
    repeat (3) tick();
    #1;
    tests_run++; if (fif.dec_valid !== 1'b1 || fif.imem_req !== 1'b0) begin tests_failed++; $display("FAIL mid_full: got valid %b req %b want 1 0", fif.dec_valid, fif.imem_req); end
    reset = 1'b0;
    tick(); #1;
    tests_run++; if (fif.dec_valid !== 1'b0 || fif.imem_req !== 1'b0) begin tests_failed++; $display("FAIL mid_reset: got valid %b req %b want 0 0", fif.dec_valid, fif.imem_req); end
    tests_run++; if (fif.inst_pc !== 32'h0 || fif.halted !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_out: got pc %h halted %b want 0 0", fif.inst_pc, fif.halted); end
`ifdef MIPS_FETCH_STATS_EN
    tests_run++; if (fetch_count !== 32'h0) begin tests_failed++; $display("FAIL mid_count: got %0d want 0", fetch_count); end
`endif
    fif.dec_ready = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    tests_run++; if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h0040_0000) begin tests_failed++; $display("FAIL mid_restart: got req %b addr %h want 1 00400000", fif.imem_req, fif.imem_addr); end
    tick(); tick(); #1;
    tests_run++; if (fif.dec_valid !== 1'b1 || fif.inst_pc !== 32'h0040_0000) begin tests_failed++; $display("FAIL mid_first: got valid %b pc %h want 1 00400000", fif.dec_valid, fif.inst_pc); end
    tick();
  endtask

  task automatic test_except();
    #1;
    tests_run++; if (fif.inst_pc !== 32'h0040_0004) begin tests_failed++; $display("FAIL exc_pre: got %h want 00400004", fif.inst_pc); end
    tick(); tick();
    fif.except = 1'b1;
    fif.redirect_valid = 1'b1;
    fif.redirect_pc = 32'h0040_0200;
    #1;
    tests_run++; if (fif.dec_valid !== 1'b1 || fif.inst_pc !== 32'h0040_000C) begin tests_failed++; $display("FAIL exc_head: got valid %b pc %h want 1 0040000c", fif.dec_valid, fif.inst_pc); end
    tick();
    fif.except = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests_run++; if (fif.halted !== 1'b1 || fif.fault_pc !== 32'h0040_000C) begin tests_failed++; $display("FAIL exc_halt %0d: got halted %b fault_pc %h want 1 0040000c", k, fif.halted, fif.fault_pc); end
      tests_run++; if (fif.dec_valid !== 1'b0 || fif.imem_req !== 1'b0) begin tests_failed++; $display("FAIL exc_quiet %0d: got valid %b req %b want 0 0", k, fif.dec_valid, fif.imem_req); end
`ifdef MIPS_FETCH_STATS_EN
      tests_run++; if (fetch_count !== 32'd3) begin tests_failed++; $display("FAIL exc_count %0d: got %0d want 3", k, fetch_count); end
`endif
      fif.dec_ready = ~fif.dec_ready;
      tick();
    end
    fif.redirect_valid = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_except();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
